// File: rtl/cdb_arbiter_if.sv
// Execute-to-CDB bus bundle: result requests/packets and grants from the functional units, plus
// the registered CDB broadcast. The arbiter takes the slave side and the source/consumer side takes the master side.
interface cdb_arbiter_if #(
    parameter int PKT_W = 32
);
    logic             flush;
    logic             alu_req0;
    logic             alu_req1;
    logic             mdu_req;
    logic             dcache_req;
    logic [PKT_W-1:0] alu_result0;
    logic [PKT_W-1:0] alu_result1;
    logic [PKT_W-1:0] mdu_result;
    logic [PKT_W-1:0] dcache_result;
    logic             alu_cdb_gnt0;
    logic             alu_cdb_gnt1;
    logic             mdu_cdb_gnt;
    logic             dcache_cdb_gnt;
    logic [PKT_W-1:0] cdb_port0;
    logic [PKT_W-1:0] cdb_port1;
    logic             cdb_val0;
    logic             cdb_val1;

    modport master (
        output flush, alu_req0, alu_req1, mdu_req, dcache_req,
        output alu_result0, alu_result1, mdu_result, dcache_result,
        input  alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt,
        input  cdb_port0, cdb_port1, cdb_val0, cdb_val1
    );

    modport slave (
        input  flush, alu_req0, alu_req1, mdu_req, dcache_req,
        input  alu_result0, alu_result1, mdu_result, dcache_result,
        output alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt,
        output cdb_port0, cdb_port1, cdb_val0, cdb_val1
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of four execute results onto two registered CDB ports.
// Optional macro CDB_DCACHE_PRIO_EN: dcache always takes port 0; round-robin covers sources 0-2.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int NUM_CDB = 2,
    parameter int PKT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic [NUM_CDB-1:0] found;
    logic               en;
    logic [1:0]         idx;
    logic [1:0]         sel0;
    logic [1:0]         sel1;
    logic [1:0]         rr_q, rr_d;
    logic [PKT_W-1:0]   pkt [NUM_SRC];
    logic [PKT_W-1:0]   port0_q, port1_q;
    logic [NUM_CDB-1:0] val_q;

    assign req    = {bus.dcache_req, bus.mdu_req, bus.alu_req1, bus.alu_req0};
    assign pkt[0] = bus.alu_result0;
    assign pkt[1] = bus.alu_result1;
    assign pkt[2] = bus.mdu_result;
    assign pkt[3] = bus.dcache_result;
    assign en     = rst && !bus.flush;

    always_comb begin
        found = '0;
        sel0  = '0;
        sel1  = '0;
        idx   = '0;
        rr_d  = rr_q;
        gnt   = '0;
`ifdef CDB_DCACHE_PRIO_EN
        if (req[3]) begin
            found[0] = 1'b1;
            sel0     = 2'd3;
        end
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = rr_q + k[1:0];
            if (idx != 2'd3 && req[idx]) begin
                if (!found[0]) begin
                    found[0] = 1'b1;
                    sel0     = idx;
                end else if (!found[1]) begin
                    found[1] = 1'b1;
                    sel1     = idx;
                end
            end
        end
        if (!en) found = '0;
        // dcache grants never move the pointer; only the last of sources 0-2 does
        if (found[1])
            rr_d = sel1 + 2'd1;
        else if (found[0] && sel0 != 2'd3)
            rr_d = sel0 + 2'd1;
`else
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = rr_q + k[1:0];
            if (req[idx]) begin
                if (!found[0]) begin
                    found[0] = 1'b1;
                    sel0     = idx;
                end else if (!found[1]) begin
                    found[1] = 1'b1;
                    sel1     = idx;
                end
            end
        end
        if (!en) found = '0;
        if (found[1])
            rr_d = sel1 + 2'd1;
        else if (found[0])
            rr_d = sel0 + 2'd1;
`endif
        if (found[0]) gnt[sel0] = 1'b1;
        if (found[1]) gnt[sel1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q    <= '0;
            val_q   <= '0;
            port0_q <= '0;
            port1_q <= '0;
        end else begin
            rr_q  <= rr_d;
            val_q <= found;
            if (found[0]) port0_q <= pkt[sel0];
            if (found[1]) port1_q <= pkt[sel1];
        end
    end

    assign bus.alu_cdb_gnt0   = gnt[0];
    assign bus.alu_cdb_gnt1   = gnt[1];
    assign bus.mdu_cdb_gnt    = gnt[2];
    assign bus.dcache_cdb_gnt = gnt[3];
    assign bus.cdb_port0      = port0_q;
    assign bus.cdb_port1      = port1_q;
    assign bus.cdb_val0       = val_q[0];
    assign bus.cdb_val1       = val_q[1];
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed grant vectors {dcache,mdu,alu1,alu0} and CDB contents.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [31:0] PA0 = 32'hA0A0_0001;
    localparam logic [31:0] PA1 = 32'hA1A1_0002;
    localparam logic [31:0] PM  = 32'hDDDD_0003;
    localparam logic [31:0] PD  = 32'hDCDC_0004;

    cdb_arbiter_if #(.PKT_W(32)) bus ();

    cdb_arbiter #(.NUM_SRC(4), .NUM_CDB(2), .PKT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic [3:0] rq);
        rst            = r;
        bus.flush      = fl;
        bus.alu_req0   = rq[0];
        bus.alu_req1   = rq[1];
        bus.mdu_req    = rq[2];
        bus.dcache_req = rq[3];
    endtask

    function automatic logic [31:0] gnts();
        return {28'd0, bus.dcache_cdb_gnt, bus.mdu_cdb_gnt, bus.alu_cdb_gnt1, bus.alu_cdb_gnt0};
    endfunction

    // One cycle: check comb grants mid-cycle, clock, then check the registered CDB.
    task automatic step(input string tag, input logic [3:0] exp_g, input logic ev0, input logic ev1,
                        input logic [31:0] ep0, input logic [31:0] ep1, input logic chk_p);
        @(negedge clk);
        chk({tag, ".gnt"}, gnts(), {28'd0, exp_g});
        @(posedge clk);
        #1;
        chk({tag, ".val0"}, {31'd0, bus.cdb_val0}, {31'd0, ev0});
        chk({tag, ".val1"}, {31'd0, bus.cdb_val1}, {31'd0, ev1});
        if (chk_p && ev0) chk({tag, ".port0"}, bus.cdb_port0, ep0);
        if (chk_p && ev1) chk({tag, ".port1"}, bus.cdb_port1, ep1);
    endtask

    initial begin
        bus.alu_result0   = PA0;
        bus.alu_result1   = PA1;
        bus.mdu_result    = PM;
        bus.dcache_result = PD;
        drive(1'b0, 1'b0, 4'b1111);
        #1;

        step("rst_a", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);
        step("rst_b", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("rst.port0", bus.cdb_port0, 32'd0);
        chk("rst.port1", bus.cdb_port1, 32'd0);
        drive(1'b1, 1'b0, 4'b1111);

`ifdef CDB_DCACHE_PRIO_EN
        step("prio1", 4'b1001, 1'b1, 1'b1, PD, PA0, 1'b1);
        step("prio2", 4'b1010, 1'b1, 1'b1, PD, PA1, 1'b1);
        step("prio3", 4'b1100, 1'b1, 1'b1, PD, PM, 1'b1);
        drive(1'b1, 1'b0, 4'b1000);
        step("prio_donly", 4'b1000, 1'b1, 1'b0, PD, '0, 1'b1);
        drive(1'b1, 1'b0, 4'b0111);
        step("prio_hold", 4'b0011, 1'b1, 1'b1, PA0, PA1, 1'b1);
`else
        step("full1", 4'b0011, 1'b1, 1'b1, PA0, PA1, 1'b1);
        step("full2", 4'b1100, 1'b1, 1'b1, PM, PD, 1'b1);
        step("full3", 4'b0011, 1'b1, 1'b1, PA0, PA1, 1'b1);
        step("full4", 4'b1100, 1'b1, 1'b1, PM, PD, 1'b1);

        drive(1'b1, 1'b0, 4'b0100);
        step("single", 4'b0100, 1'b1, 1'b0, PM, '0, 1'b1);

        drive(1'b1, 1'b0, 4'b1001);
        bus.dcache_result = 32'h1234_5678;
        step("wrap", 4'b1001, 1'b1, 1'b1, 32'h1234_5678, PA0, 1'b1);
        bus.dcache_result = PD;

        drive(1'b1, 1'b1, 4'b1111);
        step("flush", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 4'b1111);
        step("post_flush", 4'b0110, 1'b1, 1'b1, PA1, PM, 1'b1);
        step("from3", 4'b1001, 1'b1, 1'b1, PD, PA0, 1'b1);
`endif

        drive(1'b0, 1'b0, 4'b1111);
        step("midrst", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("midrst.port0", bus.cdb_port0, 32'd0);
        drive(1'b0, 1'b0, 4'b0110);
        step("midrst_b", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 4'b0110);
        step("rst_rel", 4'b0110, 1'b1, 1'b1, PA1, PM, 1'b1);

        drive(1'b1, 1'b0, 4'b0000);
        step("idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the four execute-stage result sources (alu_result0, alu_result1, mdu_result, dcache_result) onto the two common data bus ports each cycle.
- Returns same-cycle grants to the functional units and drives registered CDB ports to the ROB, reservation stations and execute forwarding.
- Round-robin fairness with a rotating priority pointer; sits between execute and the CDB consumers.

Parameters:
- NUM_SRC, 4, number of requesters; fixed order 0=alu0, 1=alu1, 2=mdu, 3=dcache; only 4 is supported.
- NUM_CDB, 2, number of CDB ports; only 2 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low: state clears on a rising clk edge while rst=0.
- flush  in  1  pipeline flush (mispredict); no grants this cycle, CDB valids cleared next edge.
- alu_req0, alu_req1, mdu_req, dcache_req  in  1 each  result-valid request from each source.
- alu_result0, alu_result1, mdu_result, dcache_result  in  $bits(writeback_packet_t) each  result packets, held stable while the request is high.
- alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt  out  1 each  combinational grant; the source treats its packet as consumed at this edge.
- cdb_port0, cdb_port1  out  $bits(writeback_packet_t) each  registered broadcast packets.
- cdb_val0, cdb_val1  out  1 each  registered broadcast valid.

Behaviour:
- Reset (rst=0 at a clk edge): rr_ptr=0, cdb_val0=0, cdb_val1=0, cdb_port0='0, cdb_port1='0. Grants are forced to 0 while rst=0.
- Request vector: req[3:0] = {dcache_req, mdu_req, alu_req1, alu_req0}.
- Grant selection (combinational, no flush):
  - Scan indices rr_ptr, rr_ptr+1, … mod 4.
  - The first requester found is granted port 0; the second is granted port 1.
  - At most 2 grants per cycle. Unselected requesters get gnt=0 and must hold packet and request.
- Grant to CDB latency: 1 cycle.
  - At the edge after a grant, cdb_portN <= packet of the source granted port N, and cdb_valN <= 1.
  - A port with no grant gets cdb_valN <= 0; cdb_portN holds its previous contents (don't-care when invalid).
- Single request: always goes to port 0; port 1 invalid.
- Port ordering: port 0 always carries the earlier index in rotated order. Consumers must not depend on program order across ports.
- rr_ptr update (only when at least one grant):
  - rr_ptr <= (index of the last granted source + 1) mod 4.
  - "Last granted" means the port-1 source if two grants, otherwise the port-0 source.
  - No grants: rr_ptr holds.
- Wrap-around: with rr_ptr=3 and req=4'b1001, dcache(3) goes to port 0, alu0(0) to port 1, and rr_ptr becomes 1.
- Fairness: a continuously requesting source is granted within 2 cycles under full load (all 4 requesting).
- Flush=1:
  - All grants are 0 that cycle.
  - cdb_val0 and cdb_val1 are 0 after the edge.
  - rr_ptr holds.
  - Requests present during flush are neither consumed nor broadcast. Sources are responsible for dropping their own flushed results.
- Reset mid-operation: a pending grant is discarded; outputs take reset values at that edge; grants are 0 while rst=0.
- Requests deasserted without a grant are legal and leave no state.

Optional Feature:
- Macro: CDB_DCACHE_PRIO_EN.
- Defined:
  - dcache_req, when high, always receives port 0, regardless of rr_ptr.
  - The remaining port goes to the first requester among indices 0–2 in rotated order starting at rr_ptr, skipping 3.
  - rr_ptr update uses only non-dcache grants: the last granted index among 0–2, +1, mod 4. A cycle with only a dcache grant holds rr_ptr.
- Undefined: dcache participates in round-robin as index 3 exactly as described in Behaviour.

Test Plan:
- Reset: hold rst=0 two cycles with all requests high -> all grants 0, cdb_val0=cdb_val1=0. Release; next cycle rr_ptr=0 -> alu_cdb_gnt0=1, alu_cdb_gnt1=1; one edge later cdb_port0=alu_result0, cdb_port1=alu_result1, both valids 1.
- Full load, 4 cycles with all requests high and fixed packets -> grant pairs {0,1},{2,3},{0,1},{2,3}; every source granted within 2 cycles.
- Single request: only mdu_req, rr_ptr=0 -> mdu_cdb_gnt=1 on port 0, cdb_val1=0 next cycle, rr_ptr=3.
- Wrap-around: rr_ptr=3, dcache_req and alu_req0 high -> dcache on port 0, alu0 on port 1, rr_ptr=1.
- Flush: all requests high with flush=1 -> all grants 0, valids 0 next cycle, rr_ptr unchanged. Next cycle, flush=0 -> normal grants resume from the same rr_ptr.
- CDB_DCACHE_PRIO_EN: rr_ptr=0, all requests high for 3 cycles -> port 0=dcache every cycle; port 1 = alu0, alu1, mdu in turn. Without the macro, the same stimulus gives the full-load pattern above.
